// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parametrised streaming CRC engine with valid/ready input and start/done result.
// Optional feature macro: CRC_CHECK_EN adds the RESIDUE parameter and the crc_ok output.
// Ports:
//   clock        rising-edge system clock
//   reset        synchronous active-low reset
//   start_port   begin a new frame (accepted in IDLE and FINAL)
//   data         input word, byte 0 = data[7:0] processed first
//   data_valid   input word valid
//   data_last    final word of the frame
//   data_keep    byte enables, only honoured on the last beat
//   data_ready   engine accepts a word this cycle
//   busy         frame in progress
//   done_port    one-cycle pulse when return_port is updated
//   return_port  final CRC (register XOR XOR_OUT), held until the next done_port
//   crc_ok       residue match, registered with done_port (CRC_CHECK_EN only)
module crc_stream_engine #(
    parameter int          DATA_W    = 8,
    parameter int          CRC_W     = 32,
    parameter logic [31:0] POLY      = 32'h04C11DB7,
    parameter logic [31:0] INIT      = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT   = 32'hFFFFFFFF,
    parameter int          LSB_FIRST = 1
`ifdef CRC_CHECK_EN
    ,
    parameter logic [31:0] RESIDUE   = 32'hDEBB20E3
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_port,
    input  logic [DATA_W-1:0]   data,
    input  logic                data_valid,
    input  logic                data_last,
    input  logic [DATA_W/8-1:0] data_keep,
    output logic                data_ready,
    output logic                busy,
    output logic                done_port,
    output logic [CRC_W-1:0]    return_port
`ifdef CRC_CHECK_EN
    ,
    output logic                crc_ok
`endif
);
    localparam int NB = DATA_W / 8;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    function automatic logic [CRC_W-1:0] reflect(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
        return r;
    endfunction

    localparam logic [CRC_W-1:0] P      = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RP     = reflect(POLY[CRC_W-1:0]);
    localparam logic [CRC_W-1:0] INIT_V = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XO_V   = XOR_OUT[CRC_W-1:0];

    // Serial bitwise CRC over the first n bytes of w, fully unrolled into one cycle.
    function automatic logic [CRC_W-1:0] update(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] w, input int n);
        logic [CRC_W-1:0] c;
        logic fb;
        c = c_in;
        for (int b = 0; b < NB; b++) begin
            if (b < n) begin
                for (int i = 0; i < 8; i++) begin
                    if (LSB_FIRST != 0) begin
                        fb = c[0] ^ w[8*b+i];
                        c  = (c >> 1) ^ (fb ? RP : '0);
                    end else begin
                        fb = c[CRC_W-1] ^ w[8*b+7-i];
                        c  = (c << 1) ^ (fb ? P : '0);
                    end
                end
            end
        end
        return c;
    endfunction

    logic [1:0]       state;
    logic [CRC_W-1:0] crc_reg;
    int               nbytes;

    // Last beat: bytes up to the first cleared keep bit; anything beyond is dropped.
    always_comb begin
        nbytes = NB;
        if (data_last) begin
            for (int b = NB - 1; b >= 0; b--) if (!data_keep[b]) nbytes = b;
        end
    end

    assign data_ready = state == RUN;
    assign busy       = state != IDLE;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            crc_reg     <= INIT_V;
            return_port <= '0;
            done_port   <= 1'b0;
`ifdef CRC_CHECK_EN
            crc_ok      <= 1'b0;
`endif
        end else begin
            done_port <= state == FINAL;
            case (state)
                IDLE: begin
                    if (start_port) begin
                        crc_reg <= INIT_V;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (data_valid) begin
                        crc_reg <= update(crc_reg, data, nbytes);
                        if (data_last) state <= FINAL;
                    end
                end
                FINAL: begin
                    return_port <= crc_reg ^ XO_V;
`ifdef CRC_CHECK_EN
                    crc_ok      <= crc_reg == RESIDUE[CRC_W-1:0];
`endif
                    if (start_port) crc_reg <= INIT_V;
                    state <= start_port ? RUN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
